// File: rtl/ram_rr_arbiter_if.sv
// Request/response bundle for ram_rr_arbiter plus the ram-side command/return bus.
// The slave modport is the arbiter's view; master is the requester/ram environment.
interface ram_rr_arbiter_if #(
  parameter int cNumReq = 2,
  parameter int cDataW  = 8,
  parameter int cAddrW  = 4
);
  logic [cNumReq-1:0]        iReqVld;
  logic [cNumReq-1:0]        iReqWEn;
  logic [cNumReq*cAddrW-1:0] iReqAddr;
  logic [cNumReq*cDataW-1:0] iReqData;
  logic [cNumReq-1:0]        oReqRdy;
  logic [cNumReq-1:0]        oRspVld;
  logic [cDataW-1:0]         oRspData;
  logic [cAddrW-1:0]         oRspAddr;
  logic [cDataW-1:0]         oRamData;
  logic [cAddrW-1:0]         oRamAddr;
  logic                      oRamEn;
  logic                      oRamWEn;
  logic [cDataW-1:0]         iRamData;
  logic [cAddrW-1:0]         iRamAddr;
  logic                      iRamDv;
  logic                      oTagErr;

  modport master (
    output iReqVld, iReqWEn, iReqAddr, iReqData,
    output iRamData, iRamAddr, iRamDv,
    input  oReqRdy, oRspVld, oRspData, oRspAddr,
    input  oRamData, oRamAddr, oRamEn, oRamWEn, oTagErr
  );

  modport slave (
    input  iReqVld, iReqWEn, iReqAddr, iReqData,
    input  iRamData, iRamAddr, iRamDv,
    output oReqRdy, oRspVld, oRspData, oRspAddr,
    output oRamData, oRamAddr, oRamEn, oRamWEn, oTagErr
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port ram between cNumReq requesters,
// routing read returns back to their issuer through an in-flight tag pipeline.
module ram_rr_arbiter #(
  parameter int cNumReq = 2,
  parameter int cRamLat = 3,
  parameter int cDataW  = 8,
  parameter int cAddrW  = 4
) (
  input  logic            iClk,
  input  logic            iRstN,
  ram_rr_arbiter_if.slave bus
);

  localparam int cIdW  = (cNumReq > 1) ? $clog2(cNumReq) : 1;
  localparam int cCntW = $clog2(cRamLat + 1);

  typedef enum logic {sDrain, sRun} tState;

  tState            r_state;
  tState            w_state_next;
  logic [cCntW-1:0] r_drain_cnt;
  logic [cCntW-1:0] w_drain_cnt_next;
  logic             w_run;

  logic [cIdW-1:0]    r_ptr;
  logic [cIdW-1:0]    w_ptr_next;
  logic [cNumReq-1:0] w_hi_mask;
  logic [cNumReq-1:0] w_req_hi;
  logic [cNumReq-1:0] w_req_sel;
  logic [cNumReq-1:0] w_gnt;
  logic               w_accept;

  logic [cNumReq-1:0] w_id_t   [cIdW];
  logic [cNumReq-1:0] w_addr_t [cAddrW];
  logic [cNumReq-1:0] w_data_t [cDataW];
  logic [cNumReq-1:0] w_wen_t;
  logic [cIdW-1:0]    w_gnt_id;
  logic [cAddrW-1:0]  w_sel_addr;
  logic [cDataW-1:0]  w_sel_data;
  logic               w_sel_wen;

  logic              r_ram_en;
  logic              r_ram_wen;
  logic [cAddrW-1:0] r_ram_addr;
  logic [cDataW-1:0] r_ram_data;
  logic [cIdW-1:0]   r_ram_id;

  logic [cRamLat-1:0]             r_tag_vld;
  logic [cRamLat-1:0][cIdW-1:0]   r_tag_id;
  logic [cRamLat-1:0][cAddrW-1:0] r_tag_addr;
  logic                           w_head_vld;
  logic [cIdW-1:0]                w_head_id;
  logic [cAddrW-1:0]              w_head_addr;

  logic               w_ret;
  logic               w_err;
  logic [cNumReq-1:0] r_rsp_vld;
  logic [cDataW-1:0]  r_rsp_data;
  logic [cAddrW-1:0]  r_rsp_addr;
  logic               r_tag_err;

  // Drain: wait out returns of reads the unreset ram may still have in flight.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state     <= sDrain;
      r_drain_cnt <= cCntW'(cRamLat);
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    w_run            = 1'b0;
    case (r_state)
      sDrain: begin
        if (r_drain_cnt != '0) begin
          w_drain_cnt_next = r_drain_cnt - cCntW'(1);
        end
        if (r_drain_cnt <= cCntW'(1)) begin
          w_state_next = sRun;
        end
      end
      sRun: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_next = sDrain;
      end
    endcase
  end

  // Search from the pointer upward; fall back to the lowest index to wrap.
  assign w_req_hi  = bus.iReqVld & w_hi_mask;
  assign w_req_sel = (|w_req_hi) ? w_req_hi : bus.iReqVld;
  assign w_gnt     = w_run ? (w_req_sel & (~w_req_sel + cNumReq'(1))) : '0;
  assign w_accept  = |w_gnt;

  genvar gi, gj;
  generate
    for (gi = 0; gi < cNumReq; gi++) begin : g_req
      localparam logic [cIdW-1:0] cId = cIdW'(gi);
      assign w_hi_mask[gi] = (cId >= r_ptr);
      assign w_wen_t[gi]   = w_gnt[gi] & bus.iReqWEn[gi];
      for (gj = 0; gj < cIdW; gj++) begin : g_id
        assign w_id_t[gj][gi] = w_gnt[gi] & cId[gj];
      end
      for (gj = 0; gj < cAddrW; gj++) begin : g_addr
        assign w_addr_t[gj][gi] = w_gnt[gi] & bus.iReqAddr[gi*cAddrW + gj];
      end
      for (gj = 0; gj < cDataW; gj++) begin : g_data
        assign w_data_t[gj][gi] = w_gnt[gi] & bus.iReqData[gi*cDataW + gj];
      end
    end
    for (gj = 0; gj < cIdW; gj++) begin : g_id_or
      assign w_gnt_id[gj] = |w_id_t[gj];
    end
    for (gj = 0; gj < cAddrW; gj++) begin : g_addr_or
      assign w_sel_addr[gj] = |w_addr_t[gj];
    end
    for (gj = 0; gj < cDataW; gj++) begin : g_data_or
      assign w_sel_data[gj] = |w_data_t[gj];
    end
  endgenerate

  assign w_sel_wen  = |w_wen_t;
  assign w_ptr_next = (w_gnt_id == cIdW'(cNumReq - 1)) ? '0 : w_gnt_id + cIdW'(1);

  assign w_head_vld  = r_tag_vld[cRamLat-1];
  assign w_head_id   = r_tag_id[cRamLat-1];
  assign w_head_addr = r_tag_addr[cRamLat-1];

  // A mismatched address with a live head is still routed; an orphan dv is dropped.
  assign w_ret = w_run & w_head_vld & bus.iRamDv;
  assign w_err = w_run & ((bus.iRamDv & ~w_head_vld) |
                          (w_head_vld & ~bus.iRamDv) |
                          (w_head_vld & bus.iRamDv & (bus.iRamAddr != w_head_addr)));

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_ptr      <= '0;
      r_ram_en   <= 1'b0;
      r_ram_wen  <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_id   <= '0;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
      r_tag_addr <= '0;
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_tag_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_ptr_next;
      end
      r_ram_en   <= w_accept;
      r_ram_wen  <= w_sel_wen;
      r_ram_addr <= w_sel_addr;
      r_ram_data <= w_sel_data;
      r_ram_id   <= w_gnt_id;
      r_tag_vld  <= {r_tag_vld[cRamLat-2:0], r_ram_en & ~r_ram_wen};
      r_tag_id   <= {r_tag_id[cRamLat-2:0], r_ram_id};
      r_tag_addr <= {r_tag_addr[cRamLat-2:0], r_ram_addr};
      r_rsp_vld  <= w_ret ? (cNumReq'(1) << w_head_id) : '0;
      if (w_ret) begin
        r_rsp_data <= bus.iRamData;
        r_rsp_addr <= bus.iRamAddr;
      end
      if (w_err) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  assign bus.oReqRdy  = w_gnt;
  assign bus.oRamEn   = r_ram_en;
  assign bus.oRamWEn  = r_ram_wen;
  assign bus.oRamAddr = r_ram_addr;
  assign bus.oRamData = r_ram_data;
  assign bus.oRspVld  = r_rsp_vld;
  assign bus.oRspData = r_rsp_data;
  assign bus.oRspAddr = r_rsp_addr;
  assign bus.oTagErr  = r_tag_err;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: behavioural ram, round-robin/scoreboard reference model,
// directed scenarios followed by random traffic.
module tb_ram_rr_arbiter;
  localparam int N   = 2;
  localparam int LAT = 3;
  localparam int DW  = 8;
  localparam int AW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.cNumReq(N), .cDataW(DW), .cAddrW(AW)) bus ();

  ram_rr_arbiter #(.cNumReq(N), .cRamLat(LAT), .cDataW(DW), .cAddrW(AW)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  // Behavioural ram: never reset, fixed LAT-cycle read latency.
  logic [DW-1:0]  mem [1<<AW];
  logic [LAT-1:0] p_vld = '0;
  logic [DW-1:0]  p_data [LAT];
  logic [AW-1:0]  p_addr [LAT];
  logic           inj_dv;

  always @(posedge clk) begin
    if (bus.oRamEn && bus.oRamWEn) mem[bus.oRamAddr] <= bus.oRamData;
    p_vld     <= {p_vld[LAT-2:0], bus.oRamEn & ~bus.oRamWEn};
    p_data[0] <= mem[bus.oRamAddr];
    p_addr[0] <= bus.oRamAddr;
    for (int k = 1; k < LAT; k++) begin
      p_data[k] <= p_data[k-1];
      p_addr[k] <= p_addr[k-1];
    end
  end

  assign bus.iRamDv   = p_vld[LAT-1] | inj_dv;
  assign bus.iRamData = p_data[LAT-1];
  assign bus.iRamAddr = p_addr[LAT-1];

  // Reference model: pointer, shadow memory and a due-cycle response queue.
  typedef struct {
    int            due;
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] shadow [1<<AW];
  int            ptr;
  int            cyc;
  bit            model_err;
  int            n_checks;
  int            n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] wen,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.iReqVld  = vld;
    bus.iReqWEn  = wen;
    bus.iReqAddr = {a1, a0};
    bus.iReqData = {d1, d0};
  endtask

  task automatic step();
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rsp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            g;
    int            idx;
    exp_t          e;
    @(negedge clk);
    exp_gnt = '0;
    g = -1;
    if (cyc > LAT) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (g < 0 && bus.iReqVld[idx]) g = idx;
      end
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("grant", 32'(bus.oReqRdy), 32'(exp_gnt));
    if (g >= 0) begin
      a   = bus.iReqAddr[g*AW +: AW];
      d   = bus.iReqData[g*DW +: DW];
      ptr = (g + 1) % N;
      if (bus.iReqWEn[g]) begin
        shadow[a] = d;
        $display("cyc %0d: accept req%0d WR addr=0x%0h data=0x%0h", cyc, g, a, d);
      end else begin
        e.due = cyc + LAT + 2; e.id = g; e.addr = a; e.data = shadow[a];
        exp_q.push_back(e);
        $display("cyc %0d: accept req%0d RD addr=0x%0h", cyc, g, a);
      end
    end
    exp_rsp = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      exp_rsp[e.id] = 1'b1;
    end
    chk("rsp_vld", 32'(bus.oRspVld), 32'(exp_rsp));
    if (exp_rsp != '0) begin
      chk("rsp_data", 32'(bus.oRspData), 32'(e.data));
      chk("rsp_addr", 32'(bus.oRspAddr), 32'(e.addr));
      $display("cyc %0d: return req%0d addr=0x%0h data=0x%0h", cyc, e.id, bus.oRspAddr, bus.oRspData);
    end
    chk("tag_err", 32'(bus.oTagErr), 32'(model_err));
    if (inj_dv) model_err = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    drive('0, '0, '0, '0, '0, '0);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    chk("rst_rdy",      32'(bus.oReqRdy),  32'd0);
    chk("rst_rsp_vld",  32'(bus.oRspVld),  32'd0);
    chk("rst_rsp_data", 32'(bus.oRspData), 32'd0);
    chk("rst_rsp_addr", 32'(bus.oRspAddr), 32'd0);
    chk("rst_ram_en",   32'(bus.oRamEn),   32'd0);
    chk("rst_ram_addr", 32'(bus.oRamAddr), 32'd0);
    chk("rst_tag_err",  32'(bus.oTagErr),  32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 1;
    ptr       = 0;
    model_err = 1'b0;
    exp_q.delete();
    $display("reset released");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    ptr      = 0;
    model_err = 1'b0;
    inj_dv   = 1'b0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = '0;
      shadow[a] = '0;
    end
    apply_reset();

    // Drain window then first grant in cycle LAT+1.
    drive(2'b01, 2'b01, 4'h0, 4'h0, 8'h11, 8'h00);
    repeat (LAT + 1) step();

    // Move pointer back to 0, then full contention.
    drive(2'b10, 2'b11, 4'h0, 4'h1, 8'h00, 8'h22);
    step();
    drive(2'b11, 2'b11, 4'h2, 4'h3, 8'h33, 8'h44);
    repeat (4) step();
    drive(2'b10, 2'b11, 4'h2, 4'h3, 8'h33, 8'h55);
    repeat (2) step();

    // Write 0xA5 to 7 by req0, read 7 by req1 the next cycle.
    drive(2'b01, 2'b01, 4'h7, 4'h0, 8'hA5, 8'h00);
    step();
    drive(2'b10, 2'b00, 4'h0, 4'h7, 8'h00, 8'h00);
    step();
    idle(LAT + 4);

    // Back-to-back reads from req0.
    for (int i = 1; i <= 3; i++) begin
      drive(2'b01, 2'b00, 4'(i), 4'h0, 8'h00, 8'h00);
      step();
    end
    idle(LAT + 4);

    // Orphan return with nothing in flight.
    inj_dv = 1'b1;
    step();
    inj_dv = 1'b0;
    idle(4);

    // Reset with three reads in flight.
    for (int i = 4; i <= 6; i++) begin
      drive(2'b01, 2'b00, 4'(i), 4'h0, 8'h00, 8'h00);
      step();
    end
    apply_reset();
    drive(2'b11, 2'b00, 4'h4, 4'h5, 8'h00, 8'h00);
    repeat (LAT) step();
    idle(LAT + 4);

    // Random traffic on a small address space to provoke read/write hazards.
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step();
    end
    idle(LAT + 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
